// File: rtl/lbp_host_pkg.sv
// lbp_host_pkg: shared defaults and FSM state encoding for the LBP host.
package lbp_host_pkg;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16384;
  typedef enum logic [1:0] {IDLE, LOAD, SERVE, DONE} state_t;
endpackage

// File: rtl/lbp_host_ram.sv
// lbp_host_ram: one write port, one asynchronous read port, one registered read port.
module lbp_host_ram #(
  parameter int AW    = 14,
  parameter int DW    = 8,
  parameter int DEPTH = 16384
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] aaddr,
  output logic [DW-1:0] adata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    rdata <= r_mem[raddr];
  end
  assign adata = r_mem[aaddr];
endmodule

// File: rtl/lbp_host.sv
// lbp_host: serves a gray image to an LBP engine, collects its results and exposes them for readout.
module lbp_host import lbp_host_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic [ADDR_W:0]   wr_cnt,
  output logic              proto_err
);
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);
  state_t r_state, w_next;
  logic [ADDR_W:0] r_wr_cnt;
  logic r_proto_err, w_start_ok, w_load_we, w_res_we, w_bad;
  logic [DATA_W-1:0] w_gray_rd, w_res_rd, w_gray_sync_unused, w_res_async_unused;
  // Memory writes are gated by reset so an aborting edge never commits a beat.
  always_comb begin
    w_start_ok = start && (r_state == IDLE || r_state == DONE);
    w_load_we  = reset && r_state == LOAD && load_valid;
    w_res_we   = reset && r_state == SERVE && lbp_valid;
    w_bad      = ((gray_req || lbp_valid) && r_state != SERVE) ||
                 (start && (r_state == LOAD || r_state == SERVE));
    w_next     = w_start_ok ? LOAD :
                 (r_state == LOAD && load_valid && load_last) ? SERVE :
                 (r_state == SERVE && finish) ? DONE : r_state;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wr_cnt    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_wr_cnt    <= w_start_ok ? '0 :
                     (w_res_we && r_wr_cnt != CNT_MAX) ? r_wr_cnt + (ADDR_W+1)'(1) : r_wr_cnt;
      r_proto_err <= r_proto_err | w_bad;
    end
  end
  lbp_host_ram #(.AW(ADDR_W), .DW(DATA_W), .DEPTH(DEPTH)) u_gray (
    .clk(clk), .we(w_load_we), .waddr(load_addr), .wdata(load_data),
    .aaddr(gray_addr), .adata(w_gray_rd), .raddr(gray_addr), .rdata(w_gray_sync_unused)
  );
  lbp_host_ram #(.AW(ADDR_W), .DW(DATA_W), .DEPTH(DEPTH)) u_res (
    .clk(clk), .we(w_res_we), .waddr(lbp_addr), .wdata(lbp_data),
    .aaddr(rd_addr), .adata(w_res_async_unused), .raddr(rd_addr), .rdata(w_res_rd)
  );
  assign gray_ready = r_state == SERVE;
  assign done       = r_state == DONE;
  assign gray_data  = (r_state == SERVE && gray_req) ? w_gray_rd : '0;
  assign rd_data    = (r_state == DONE) ? w_res_rd : '0;
  assign wr_cnt     = r_wr_cnt;
  assign proto_err  = r_proto_err;
endmodule

// File: tb/tb_lbp_host.sv
// tb_lbp_host: directed stimulus pushes expected values into a queue; a negedge monitor pops and compares.
module tb_lbp_host;
  localparam int AW = 14, DW = 8, DEPTH = 16384;
  localparam int K_RDY = 0, K_GD = 1, K_RD = 2, K_DONE = 3, K_CNT = 4, K_ERR = 5;
  logic clk = 0, reset = 0, start = 0, load_valid = 0, load_last = 0;
  logic gray_req = 0, lbp_valid = 0, finish = 0;
  logic [AW-1:0] load_addr = '0, gray_addr = '0, lbp_addr = '0, rd_addr = '0;
  logic [DW-1:0] load_data = '0, lbp_data = '0;
  logic gray_ready, done, proto_err;
  logic [DW-1:0] gray_data, rd_data;
  logic [AW:0] wr_cnt;
  typedef struct {int due; int kind; int val; string name;} chk_t;
  chk_t q[$];
  int cyc = 0, total = 0, bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  lbp_host #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
    .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish),
    .rd_addr(rd_addr), .rd_data(rd_data), .done(done), .wr_cnt(wr_cnt), .proto_err(proto_err)
  );
  function automatic int act(int k);
    case (k)
      K_RDY:  return int'(gray_ready);
      K_GD:   return int'(gray_data);
      K_RD:   return int'(rd_data);
      K_DONE: return int'(done);
      K_CNT:  return int'(wr_cnt);
      default: return int'(proto_err);
    endcase
  endfunction
  task automatic expect_now(int k, int v, string n);
    q.push_back('{cyc, k, v, n});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      chk_t c;
      c = q.pop_front();
      total++;
      if (c.due < cyc || act(c.kind) != c.val) begin
        bad++;
        $display("FAIL %s: got %0d want %0d (cycle %0d)", c.name, act(c.kind), c.val, cyc);
      end
    end
  end
  initial begin
    step(); step();
    expect_now(K_RDY, 0, "rst_gray_ready");
    expect_now(K_DONE, 0, "rst_done");
    expect_now(K_CNT, 0, "rst_wr_cnt");
    expect_now(K_ERR, 0, "rst_proto_err");
    expect_now(K_GD, 0, "rst_gray_data");
    expect_now(K_RD, 0, "rst_rd_data");
    reset = 1; start = 1; step(); start = 0;
    expect_now(K_RDY, 0, "load_not_ready");
    for (int a = 0; a < DEPTH; a++) begin
      load_valid = 1; load_addr = AW'(a); load_data = DW'(a); load_last = (a == DEPTH-1);
      step();
    end
    load_valid = 0; load_last = 0;
    expect_now(K_RDY, 1, "ready_after_last");
    total++;
    if (gray_ready !== 1'b1) begin bad++; $display("FAIL direct ready_after_last: got %0b", gray_ready); end
    gray_req = 1; gray_addr = 300;
    expect_now(K_GD, 8'h2C, "gray_300");
    #1;
    total++;
    if (gray_data !== 8'h2C) begin bad++; $display("FAIL direct gray_300: got %0h", gray_data); end
    step();
    gray_addr = 16383;
    expect_now(K_GD, 8'hFF, "gray_16383");
    lbp_valid = 1; lbp_addr = 129; lbp_data = 8'hA5; step();
    lbp_valid = 0; gray_req = 0;
    expect_now(K_CNT, 1, "cnt_one");
    finish = 1; lbp_valid = 1; lbp_addr = 5; lbp_data = 8'h3C; step();
    finish = 0; lbp_valid = 0;
    expect_now(K_DONE, 1, "done_after_finish");
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL direct done_after_finish: got %0b", done); end
    expect_now(K_CNT, 2, "cnt_finish_edge");
    expect_now(K_RDY, 0, "not_ready_in_done");
    expect_now(K_ERR, 0, "no_err_serve");
    rd_addr = 129; step();
    expect_now(K_RD, 8'hA5, "rd_129");
    rd_addr = 5; step();
    expect_now(K_RD, 8'h3C, "rd_5_finish_edge");
    lbp_valid = 1; lbp_data = 8'h77; step(); lbp_valid = 0;
    expect_now(K_ERR, 1, "err_lbp_in_done");
    expect_now(K_CNT, 2, "cnt_ignored_write");
    step();
    expect_now(K_RD, 8'h3C, "rd_5_unchanged");
    reset = 0; step(); reset = 1;
    expect_now(K_ERR, 0, "err_cleared");
    expect_now(K_DONE, 0, "done_cleared");
    expect_now(K_RD, 0, "rd_zero_idle");
    start = 1; step(); start = 0;
    for (int a = 0; a < 4; a++) begin
      load_valid = 1; load_addr = AW'(a); load_data = DW'(8'h10 + a); load_last = (a == 3);
      step();
    end
    load_valid = 0; load_last = 0;
    expect_now(K_RDY, 1, "short_load_ready");
    expect_now(K_ERR, 0, "short_load_no_err");
    start = 1; step(); start = 0;
    expect_now(K_RDY, 1, "start_in_serve_ignored");
    expect_now(K_ERR, 1, "err_start_in_serve");
    gray_req = 1; gray_addr = 2;
    expect_now(K_GD, 8'h12, "gray_reload_2");
    step(); gray_req = 0;
    for (int i = 0; i < 10; i++) begin
      lbp_valid = 1; lbp_addr = AW'(i); lbp_data = DW'(i); step();
    end
    lbp_valid = 0;
    expect_now(K_CNT, 10, "cnt_ten");
    total++;
    if (wr_cnt !== 15'd10) begin bad++; $display("FAIL direct cnt_ten: got %0d", wr_cnt); end
    reset = 0; lbp_valid = 1; step(); reset = 1; lbp_valid = 0;
    expect_now(K_RDY, 0, "abort_ready");
    expect_now(K_CNT, 0, "abort_cnt");
    expect_now(K_ERR, 0, "abort_err");
    expect_now(K_DONE, 0, "abort_done");
    gray_req = 1; gray_addr = 300;
    expect_now(K_GD, 0, "gray_idle_zero");
    step(); gray_req = 0;
    expect_now(K_ERR, 1, "err_gray_idle");
    reset = 0; step(); reset = 1;
    start = 1; step(); start = 0;
    load_valid = 1; load_addr = 0; load_data = 8'h01; load_last = 1; step();
    load_valid = 0; load_last = 0;
    expect_now(K_RDY, 1, "single_beat_ready");
    for (int i = 0; i < DEPTH; i++) begin
      lbp_valid = 1; lbp_addr = AW'(i); lbp_data = DW'(i) ^ 8'h5A; step();
    end
    lbp_valid = 0;
    expect_now(K_CNT, DEPTH, "cnt_full");
    for (int i = 0; i < 5; i++) begin
      lbp_valid = 1; lbp_addr = AW'(i); lbp_data = 8'h99; step();
    end
    lbp_valid = 0;
    expect_now(K_CNT, DEPTH, "cnt_saturated");
    total++;
    if (wr_cnt !== 15'(DEPTH)) begin bad++; $display("FAIL direct cnt_saturated: got %0d", wr_cnt); end
    expect_now(K_ERR, 0, "no_err_full");
    finish = 1; step(); finish = 0;
    expect_now(K_DONE, 1, "done_full");
    rd_addr = 4; step();
    expect_now(K_RD, 8'h99, "rd_rewritten_4");
    rd_addr = 200; step();
    expect_now(K_RD, 8'h92, "rd_200");
    start = 1; step(); start = 0;
    expect_now(K_DONE, 0, "restart_done");
    expect_now(K_CNT, 0, "restart_cnt");
    total++;
    if (wr_cnt !== 15'd0) begin bad++; $display("FAIL direct restart_cnt: got %0d", wr_cnt); end
    expect_now(K_RDY, 0, "restart_ready");
    expect_now(K_RD, 0, "restart_rd_zero");
    expect_now(K_ERR, 0, "restart_no_err");
    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    while (q.size() > 0) begin
      chk_t c;
      c = q.pop_front();
      total++;
      bad++;
      $display("FAIL %s: never checked, want %0d", c.name, c.val);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
